// File: rtl/ssha256_msched_pkg.sv
// Shared definitions for the SHA-256 sigma unit and the message-schedule sequencer.
package ssha256_msched_pkg;

  localparam logic [1:0] SS_SIG0 = 2'b00;
  localparam logic [1:0] SS_SIG1 = 2'b01;
  localparam logic [1:0] SS_SUM0 = 2'b10;
  localparam logic [1:0] SS_SUM1 = 2'b11;

  localparam int unsigned MSCHED_LOAD_LEN = 16;

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_SIG0 = 2'b01,
    ST_SIG1 = 2'b10,
    ST_OUT  = 2'b11
  } msched_state_e;

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/ssha256_msched_sigma.sv
// SHA-256 sigma/Sigma unit: one 32-bit combinational function selected by ss.
module ssha256
  import ssha256_msched_pkg::*;
(
  input  logic [1:0]  ss,
  input  logic [31:0] rs1,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (ss)
      SS_SIG0: result = rotr32(rs1, 7)  ^ rotr32(rs1, 18) ^ (rs1 >> 3);
      SS_SIG1: result = rotr32(rs1, 17) ^ rotr32(rs1, 19) ^ (rs1 >> 10);
      SS_SUM0: result = rotr32(rs1, 2)  ^ rotr32(rs1, 13) ^ rotr32(rs1, 22);
      SS_SUM1: result = rotr32(rs1, 6)  ^ rotr32(rs1, 11) ^ rotr32(rs1, 25);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ssha256_msched.sv
// SHA-256 message-schedule sequencer: loads W[0..15], emits W[16..SCHED_LEN-1]
// using one shared sigma unit (sigma0 then sigma1 per word).
module ssha256_msched
  import ssha256_msched_pkg::*;
#(
  parameter int unsigned SCHED_LEN = 64
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        busy
);

  localparam logic [3:0] CNT_LAST = 4'(MSCHED_LOAD_LEN - 1);
  localparam logic [5:0] T_FIRST  = 6'(MSCHED_LOAD_LEN);
  localparam logic [5:0] T_LAST   = 6'(SCHED_LEN - 1);

  msched_state_e state;
  logic [3:0]    cnt;
  logic [5:0]    t;
  logic [31:0]   s0_q;
  logic [31:0]   win [16];

  logic [1:0]    sig_ss;
  logic [31:0]   sig_rs1;
  logic [31:0]   sig_res;
  logic [31:0]   next_word;
  logic          load_xfer;
  logic          out_xfer;

  ssha256 u_sigma (
    .ss     (sig_ss),
    .rs1    (sig_rs1),
    .result (sig_res)
  );

  always_comb begin
    sig_ss  = SS_SIG0;
    sig_rs1 = win[1];
    if (state == ST_SIG1) begin
      sig_ss  = SS_SIG1;
      sig_rs1 = win[14];
    end
  end

  assign next_word = sig_res + win[9] + s0_q + win[0];

  // Flush and reset both suppress any same-cycle transfer, including the window shift.
  assign load_xfer = !g_reset && !flush && (state == ST_LOAD) && in_valid;
  assign out_xfer  = !g_reset && !flush && (state == ST_OUT) && out_valid && out_ready;

  always_ff @(posedge g_clk) begin
    if (load_xfer || out_xfer) begin
      for (int unsigned i = 0; i < 15; i++) begin
        win[i] <= win[i+1];
      end
      win[15] <= load_xfer ? in_word : out_word;
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      t         <= T_FIRST;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      state     <= ST_LOAD;
      cnt       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 4'd1;
            if (cnt == CNT_LAST) begin
              state    <= ST_SIG0;
              t        <= T_FIRST;
              busy     <= 1'b1;
              in_ready <= 1'b0;
            end
          end
        end
        ST_SIG0: begin
          s0_q  <= sig_res;
          state <= ST_SIG1;
        end
        ST_SIG1: begin
          out_word  <= next_word;
          out_idx   <= t;
          out_valid <= 1'b1;
          state     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (t == T_LAST) begin
              state    <= ST_LOAD;
              cnt      <= '0;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              t     <= t + 6'd1;
              state <= ST_SIG0;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ssha256_msched.sv
// Self-checking bench for ssha256_msched: reference schedule model feeding a
// scoreboard queue, plus a table of known SHA-256 schedule words.
module tb_ssha256_msched;

  localparam int SL = 64;

  logic        g_clk;
  logic        g_reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_idx;
  logic        busy;

  ssha256_msched #(.SCHED_LEN(SL)) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_idx   (out_idx),
    .busy      (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    int          pat;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  localparam int PAT_ABC  = 0;
  localparam int PAT_ONES = 1;
  localparam int PAT_ZERO = 2;

  int          n_checks;
  int          n_pass;
  exp_t        sbq[$];
  vec_t        vecs[8];
  logic [31:0] blk[16];
  logic [31:0] mw[64];
  logic [31:0] got[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x};
    return d[n +: 32];
  endfunction

  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
  endfunction

  task automatic set_block(input int pat);
    for (int i = 0; i < 16; i++) begin
      case (pat)
        PAT_ABC:  blk[i] = (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
        PAT_ONES: blk[i] = 32'hFFFFFFFF;
        default:  blk[i] = 32'h0;
      endcase
    end
    for (int i = 0; i < 16; i++) mw[i] = blk[i];
    for (int i = 16; i < 64; i++)
      mw[i] = bs1(mw[i-2]) + mw[i-7] + bs0(mw[i-15]) + mw[i-16];
    for (int i = 0; i < 64; i++) got[i] = 32'hDEADBEEF;
  endtask

  task automatic load_block();
    int i;
    int guard;
    logic rdy;
    i = 0;
    guard = 0;
    in_valid = 1'b1;
    while (i < 16 && guard < 200) begin
      in_word = blk[i];
      rdy = in_ready;
      step();
      if (rdy) i++;
      guard++;
    end
    in_valid = 1'b0;
    if (i < 16) chk("load_timeout", 32'(i), 32'd16);
    for (int k = 16; k < SL; k++) sbq.push_back('{idx: 6'(k), word: mw[k]});
  endtask

  task automatic load_partial(input int n, input bit use_reset);
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_word = 32'hA5A50000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    if (use_reset) g_reset = 1'b1;
    else flush = 1'b1;
    step();
    g_reset = 1'b0;
    flush = 1'b0;
    chk(use_reset ? "partial_reset_in_ready" : "partial_flush_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic collect(input int stall_idx, input int stall_len, input bit junk, input int flush_idx);
    int guard;
    int stalled;
    bit done;
    exp_t e;
    guard = 0;
    stalled = 0;
    done = 0;
    while (!done && guard < 2000) begin
      guard++;
      if (junk) begin
        in_valid = 1'b1;
        in_word = $urandom;
      end
      out_ready = 1'b1;
      if (out_valid && int'(out_idx) == flush_idx) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        sbq.delete();
        done = 1;
      end else if (out_valid && int'(out_idx) == stall_idx && stalled < stall_len) begin
        out_ready = 1'b0;
        chk("stall_word", out_word, 32'h000F0000);
        chk("stall_idx", 32'(out_idx), 32'd17);
        stalled++;
        step();
      end else if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_output", 32'(out_idx), 32'd0);
          done = 1;
        end else begin
          e = sbq.pop_front();
          chk("sb_word", out_word, e.word);
          chk("sb_idx", 32'(out_idx), 32'(e.idx));
          got[out_idx] = out_word;
          if (sbq.size() == 0) begin
            in_valid = 1'b0;
            step();
            out_ready = 1'b0;
            chk("end_in_ready", 32'(in_ready), 32'd1);
            chk("end_busy", 32'(busy), 32'd0);
            done = 1;
          end else begin
            step();
          end
        end
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    if (!done) chk("collect_timeout", 32'(sbq.size()), 32'd0);
    sbq.delete();
  endtask

  task automatic check_table(input int pat);
    for (int i = 0; i < 8; i++)
      if (vecs[i].pat == pat) chk("table_word", got[vecs[i].idx], vecs[i].exp);
  endtask

  task automatic check_latency();
    chk("lat_busy", 32'(busy), 32'd1);
    chk("lat_cyc1_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_cyc2_out_valid", 32'(out_valid), 32'd0);
    step();
    chk("lat_cyc3_out_valid", 32'(out_valid), 32'd1);
    chk("lat_first_idx", 32'(out_idx), 32'd16);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    vecs[0] = '{PAT_ABC, 16, 32'h61626380};
    vecs[1] = '{PAT_ABC, 17, 32'h000F0000};
    vecs[2] = '{PAT_ABC, 18, 32'h7DA86405};
    vecs[3] = '{PAT_ABC, 19, 32'h600003C6};
    vecs[4] = '{PAT_ABC, 63, 32'h12B1EDEB};
    vecs[5] = '{PAT_ONES, 16, 32'h203FFFFC};
    vecs[6] = '{PAT_ZERO, 16, 32'h0};
    vecs[7] = '{PAT_ZERO, 63, 32'h0};

    g_reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_word = '0;
    out_ready = 1'b0;
    step();
    step();
    g_reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_idx", 32'(out_idx), 32'd0);
    chk("rst_out_word", out_word, 32'd0);

    // abc block with latency check, no backpressure
    set_block(PAT_ABC);
    load_block();
    check_latency();
    collect(-1, 0, 0, -1);
    check_table(PAT_ABC);

    // backpressure at t=17
    set_block(PAT_ABC);
    load_block();
    collect(17, 10, 0, -1);
    check_table(PAT_ABC);

    // wrap arithmetic
    set_block(PAT_ONES);
    load_block();
    collect(-1, 0, 0, -1);
    check_table(PAT_ONES);

    set_block(PAT_ZERO);
    load_block();
    collect(-1, 0, 0, -1);
    check_table(PAT_ZERO);
    for (int i = 16; i < SL; i++) chk("zero_word", got[i], 32'h0);

    // flush with simultaneous out_ready at idx 30, then a fresh block
    set_block(PAT_ABC);
    load_block();
    collect(-1, 0, 0, 30);
    set_block(PAT_ABC);
    load_block();
    collect(-1, 0, 0, -1);
    check_table(PAT_ABC);

    // reset mid-load, flush mid-load, junk in_valid during expansion
    load_partial(7, 1'b1);
    load_partial(5, 1'b0);
    set_block(PAT_ABC);
    load_block();
    collect(-1, 0, 1, -1);
    check_table(PAT_ABC);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
